steer_sequencer: RTL and testbench
==================================

# steer_sequencer

Controller that sequences the byte-steering stage of the neighbourhood pipeline. It accepts packed 32-bit pixel words from the line buffer and keeps them in a two-word ring (8 pixels) that drives the steering stage's `in1`/`in2`. It advances the steering `sel` as a circular read pointer and presents a sliding window of `WIN` pixels, stepped by `STRIDE` pixels, to the neighbourhood operator under a valid/ready handshake, with row-end flush.

## Interface
- `WIN`, 4: window width in pixels; legal 2..5; taps `out1..outWIN` of the steering stage.
- `STRIDE`, 1: pixels advanced per accepted window; legal 1..`WIN`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_data` in 32: four pixels, pixel 0 in `[7:0]`.
- `in_valid` in 1 / `in_ready` out 1: input handshake.
- `in_last` in 1: qualifies `in_data`; last word of a row.
- `steer_in1` out 32, `steer_in2` out 32: ring bank 0 / bank 1 (ring pixel indices 0..3 / 4..7).
- `steer_sel` out 3: ring index of the oldest valid pixel (read pointer).
- `steer_en` out 1: steering-stage enable.
- `win_valid` out 1 / `win_ready` in 1: window handshake. Window is on the steering outputs.
- `win_last` out 1: qualifies `win_valid`; final window of the row.

## Operation
- State: `fill` (4b, 0..8), `ptr` (3b, mod 8, drives `steer_sel`), `wbank` (1b), `last_pending`, FSM {FILL, PRESENT, FLUSH}.
- Reset values: all regs 0, state FILL. Outputs during reset: `steer_in1/2` 0, `steer_sel` 0, `steer_en` 0, `win_valid` 0, `win_last` 0, `in_ready` 0.
- `steer_en` is a register. It goes to 1 on the first edge after reset release and stays 1. The steering stage never sees en=0 outside reset.
- Load: `in_ready = steer_en & ~last_pending & (state != FLUSH) & (fill <= 4)`. On handshake, `in_data` is written to bank `wbank`, `wbank` toggles, `fill += 4`, and `last_pending |= in_last`. The write tail is always 4-aligned.
- Loads are legal in PRESENT. The written bank holds no window pixels.
- FILL -> PRESENT when `fill >= WIN`.
- FILL -> FLUSH when `last_pending & fill < WIN` (runt tail).
- PRESENT: `win_valid = 1`, and `win_last = last_pending & (fill - STRIDE < WIN)`.
- On `win_ready`: `ptr += STRIDE` (wraps mod 8), `fill -= STRIDE`. Next state is FLUSH if `win_last`, else FILL.
- A load and an advance on the same edge give `fill += 4 - STRIDE`.
- FLUSH lasts one cycle. It discards the remaining `fill` pixels, clears `fill`, `ptr`, `wbank`, `last_pending`, then goes to FILL. The next row starts at `steer_sel` 0.
- While `win_valid & ~win_ready`, `ptr` and the window bytes are frozen. `steer_in*` change only in the free bank.
- The ring is deadlock-free because `WIN <= 5`: `fill <= 4` permits a load and `fill >= WIN` permits an emit.

## Timing
- Load accepted in cycle t, making `fill >= WIN`:
  - cycle t+1: FILL.
  - edge t+1: state enters PRESENT and the steering stage captures.
  - cycle t+2: `win_valid` = 1 with valid window data.
- Window accepted in cycle p: cycle p+1 is FILL (re-evaluate). Next `win_valid` no earlier than p+2. Peak rate is one window per 2 cycles.
- `in_ready`, `win_valid`, `win_last` are decoded from registers only. There is no combinational path from `in_valid` or `win_ready`.
- Reset asserted mid-operation clears state immediately. An in-flight window is lost, and steering-stage contents are don't-care while `win_valid` = 0.

## Configuration
- `STEER_SEQ_STATS_EN` defined adds two outputs:
  - `stat_windows` out 16: saturating count of window handshakes.
  - `stat_discard` out 16: saturating sum of `fill` at each FLUSH.
  - Both reset to 0 and are cleared only by reset.
- Without the macro, the ports and counters are absent; all other behaviour is identical.

## Test plan
- WIN=4, STRIDE=1: load 0x03020100, 0x07060504 -> first `win_valid` 2 cycles after the first load, `steer_sel` 0, window bytes 00..03; with `win_ready` tied 1, subsequent windows arrive at `steer_sel` 1, 2, 3…, one every 2 cycles.
- Backpressure: `win_ready` = 0 for 5 cycles in PRESENT -> `win_valid`, `steer_sel` and window bytes held constant throughout; the free bank may load.
- WIN=4, STRIDE=2, two words, second with `in_last` -> windows at `steer_sel` 0, 2, 4, `win_last` on the third; FLUSH discards 2 pixels (`stat_discard` = 2, `stat_windows` = 3); the next row starts at `steer_sel` 0.
- Runt row, WIN=5: a single word with `in_last` -> no `win_valid`; FLUSH with `stat_discard` += 4; `in_ready` = 0 from the load until FLUSH completes.
- WIN=4, STRIDE=3, `fill` = 4 in PRESENT with `in_valid` and `win_ready` both 1 -> load and advance on the same edge, `fill` = 5, `steer_sel` += 3.
- `rst_n` pulled low mid-PRESENT -> `win_valid`, `in_ready`, `steer_en` go 0 immediately (asynchronously); after release `in_ready` = 1 on the second cycle.

Source files
------------

// File: rtl/steer_sequencer.sv
// rtl/steer_sequencer.sv - byte-steering ring sequencer with sliding window emit and row-end flush (option: STEER_SEQ_STATS_EN)
module steer_sequencer #(
  parameter int WIN    = 4,
  parameter int STRIDE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  output logic [31:0] steer_in1,
  output logic [31:0] steer_in2,
  output logic [2:0]  steer_sel,
  output logic        steer_en,
  output logic        win_valid,
  input  logic        win_ready,
  output logic        win_last
`ifdef STEER_SEQ_STATS_EN
  ,
  output logic [15:0] stat_windows,
  output logic [15:0] stat_discard
`endif
);

  typedef enum logic [1:0] {S_FILL, S_PRESENT, S_FLUSH} state_t;

  localparam logic [3:0] C_WIN    = 4'(WIN);
  localparam logic [3:0] C_STRIDE = 4'(STRIDE);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_bank0, r_bank1;
  logic [3:0]  r_fill, w_fill_nxt;
  logic [2:0]  r_ptr, w_ptr_nxt;
  logic        r_wbank, w_wbank_nxt;
  logic        r_last_pending, w_last_pending_nxt;
  logic        r_steer_en;
  logic        w_load, w_adv;

  // Handshake qualifiers come from registers only, so neither input valid/ready
  // reaches an output combinationally.
  assign in_ready  = r_steer_en & ~r_last_pending & (r_state != S_FLUSH) & (r_fill <= 4'd4);
  assign win_valid = (r_state == S_PRESENT);
  assign win_last  = win_valid & r_last_pending & ((r_fill - C_STRIDE) < C_WIN);
  assign w_load    = in_ready & in_valid;
  assign w_adv     = win_valid & win_ready;

  assign steer_in1 = r_bank0;
  assign steer_in2 = r_bank1;
  assign steer_sel = r_ptr;
  assign steer_en  = r_steer_en;

  // Next-state and ring bookkeeping; fill accounts for a load and an advance on the same edge.
  always_comb begin
    w_state_nxt        = r_state;
    w_ptr_nxt          = r_ptr;
    w_wbank_nxt        = r_wbank;
    w_last_pending_nxt = r_last_pending;
    w_fill_nxt         = 4'(r_fill + (w_load ? 4'd4 : 4'd0) - (w_adv ? C_STRIDE : 4'd0));
    if (w_load) begin
      w_wbank_nxt        = ~r_wbank;
      w_last_pending_nxt = r_last_pending | in_last;
    end
    case (r_state)
      S_FILL: begin
        if (r_fill >= C_WIN) begin
          w_state_nxt = S_PRESENT;
        end else if (r_last_pending) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_PRESENT: begin
        if (w_adv) begin
          w_ptr_nxt   = 3'(r_ptr + C_STRIDE[2:0]);
          w_state_nxt = win_last ? S_FLUSH : S_FILL;
        end
      end
      S_FLUSH: begin
        // Drop the runt tail so the next row starts at ring index 0.
        w_fill_nxt         = 4'd0;
        w_ptr_nxt          = 3'd0;
        w_wbank_nxt        = 1'b0;
        w_last_pending_nxt = 1'b0;
        w_state_nxt        = S_FILL;
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  // Control registers; steer_en rises on the first edge after reset and stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_FILL;
      r_fill         <= 4'd0;
      r_ptr          <= 3'd0;
      r_wbank        <= 1'b0;
      r_last_pending <= 1'b0;
      r_steer_en     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_fill         <= w_fill_nxt;
      r_ptr          <= w_ptr_nxt;
      r_wbank        <= w_wbank_nxt;
      r_last_pending <= w_last_pending_nxt;
      r_steer_en     <= 1'b1;
    end
  end

  // Ring banks; only the free bank is ever written, so window bytes stay put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank0 <= 32'd0;
      r_bank1 <= 32'd0;
    end else if (w_load) begin
      if (r_wbank) begin
        r_bank1 <= in_data;
      end else begin
        r_bank0 <= in_data;
      end
    end
  end

`ifdef STEER_SEQ_STATS_EN
  logic [15:0] r_stat_windows, r_stat_discard;
  logic [16:0] w_discard_sum;

  assign w_discard_sum = {1'b0, r_stat_discard} + 17'(r_fill);
  assign stat_windows  = r_stat_windows;
  assign stat_discard  = r_stat_discard;

  // Saturating counters of accepted windows and of pixels dropped at flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_windows <= 16'd0;
      r_stat_discard <= 16'd0;
    end else begin
      if (w_adv && (r_stat_windows != 16'hffff)) begin
        r_stat_windows <= r_stat_windows + 16'd1;
      end
      if (r_state == S_FLUSH) begin
        r_stat_discard <= w_discard_sum[16] ? 16'hffff : w_discard_sum[15:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_steer_sequencer.sv
// tb/tb_steer_sequencer.sv - self-checking bench for steer_sequencer over four WIN/STRIDE configurations
module tb_steer_sequencer;

  localparam int NI = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data   [NI];
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic        in_last   [NI];
  logic [31:0] steer_in1 [NI];
  logic [31:0] steer_in2 [NI];
  logic [2:0]  steer_sel [NI];
  logic        steer_en  [NI];
  logic        win_valid [NI];
  logic        win_ready [NI];
  logic        win_last  [NI];

  int nvec;
  int nerr;

  // Instance configurations: 0:(4,1) 1:(4,2) 2:(4,3) 3:(5,1)
  function automatic int win_of(input int i);
    return (i == 3) ? 5 : 4;
  endfunction

  function automatic int str_of(input int i);
    return (i == 3) ? 1 : i + 1;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    steer_sequencer #(
      .WIN   ((g == 3) ? 5 : 4),
      .STRIDE((g == 3) ? 1 : g + 1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_last  (in_last[g]),
      .steer_in1(steer_in1[g]),
      .steer_in2(steer_in2[g]),
      .steer_sel(steer_sel[g]),
      .steer_en (steer_en[g]),
      .win_valid(win_valid[g]),
      .win_ready(win_ready[g]),
      .win_last (win_last[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Window pixels as seen through the ring at the current read pointer.
  function automatic logic [39:0] win_bytes(input int i);
    logic [63:0] r;
    logic [39:0] d;
    r = {steer_in2[i], steer_in1[i]};
    d = '0;
    for (int k = 0; k < win_of(i); k++) begin
      d[8*k +: 8] = r[8*((int'(steer_sel[i]) + k) % 8) +: 8];
    end
    return d;
  endfunction

  task automatic idle_inputs();
    for (int i = 0; i < NI; i++) begin
      in_data[i]   = 32'd0;
      in_valid[i]  = 1'b0;
      in_last[i]   = 1'b0;
      win_ready[i] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    for (int i = 0; i < NI; i++) begin
      nvec++;
      if ({steer_in1[i], steer_in2[i], steer_sel[i], steer_en[i], win_valid[i], win_last[i], in_ready[i]} !== '0) begin
        nerr++;
        $display("FAIL reset_outputs inst=%0d in1=%h in2=%h sel=%0d en=%b wv=%b wl=%b ir=%b required all 0",
                 i, steer_in1[i], steer_in2[i], steer_sel[i], steer_en[i], win_valid[i], win_last[i], in_ready[i]);
      end
    end
    rst_n = 1'b1;
    #1;
    nvec++;
    if (in_ready[0] !== 1'b0) begin
      nerr++;
      $display("FAIL reset_release_first_cycle in_ready=%b required 0", in_ready[0]);
    end
    step();
    nvec++;
    if (in_ready[0] !== 1'b1 || steer_en[0] !== 1'b1) begin
      nerr++;
      $display("FAIL reset_release_second_cycle in_ready=%b steer_en=%b required 1 1", in_ready[0], steer_en[0]);
    end
  endtask

  task automatic test_basic();
    logic [39:0] exp;
    in_valid[0] = 1'b1; in_data[0] = 32'h03020100; win_ready[0] = 1'b1;
    step();
    in_data[0] = 32'h07060504;
    nvec++;
    if (win_valid[0] !== 1'b0) begin
      nerr++; $display("FAIL basic_latency_t1 win_valid=%b required 0", win_valid[0]);
    end
    step();
    in_valid[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        nvec++;
        if (win_valid[0] !== 1'b0) begin
          nerr++; $display("FAIL basic_gap k=%0d win_valid=%b required 0", k, win_valid[0]);
        end
        step();
      end
      exp = '0;
      for (int j = 0; j < 4; j++) exp[8*j +: 8] = 8'(k + j);
      nvec++;
      if (win_valid[0] !== 1'b1 || steer_sel[0] !== 3'(k) || win_bytes(0) !== exp) begin
        nerr++;
        $display("FAIL basic_window k=%0d valid=%b sel=%0d bytes=%h required 1 %0d %h",
                 k, win_valid[0], steer_sel[0], win_bytes(0), k, exp);
      end
      step();
    end
    do_reset();
  endtask

  task automatic test_backpressure();
    int          n;
    logic [2:0]  hsel;
    logic [39:0] hdat;
    in_valid[0] = 1'b1; in_data[0] = 32'h13121110; win_ready[0] = 1'b0;
    step();
    in_valid[0] = 1'b0;
    n = 0;
    while (win_valid[0] !== 1'b1 && n < 10) begin step(); n++; end
    nvec++;
    if (win_valid[0] !== 1'b1) begin
      nerr++; $display("FAIL backpressure_timeout win_valid=%b required 1", win_valid[0]);
    end
    hsel = steer_sel[0];
    hdat = win_bytes(0);
    nvec++;
    if (hdat !== 40'h0013121110) begin
      nerr++; $display("FAIL backpressure_bytes bytes=%h required 0013121110", hdat);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = (c == 0); in_data[0] = 32'h17161514;
      step();
      nvec++;
      if (win_valid[0] !== 1'b1 || steer_sel[0] !== hsel || win_bytes(0) !== hdat) begin
        nerr++;
        $display("FAIL backpressure_hold c=%0d valid=%b sel=%0d bytes=%h required 1 %0d %h",
                 c, win_valid[0], steer_sel[0], win_bytes(0), hsel, hdat);
      end
    end
    nvec++;
    if (steer_in2[0] !== 32'h17161514) begin
      nerr++; $display("FAIL backpressure_free_bank in2=%h required 17161514", steer_in2[0]);
    end
    do_reset();
  endtask

  task automatic test_stride2();
    logic [31:0] w [3];
    logic        l [3];
    int          gsel [$];
    logic        glast [$];
    int          wi, c;
    int          esel [4];
    logic        elast [4];
    w[0] = 32'h03020100; l[0] = 1'b0;
    w[1] = 32'h07060504; l[1] = 1'b1;
    w[2] = 32'h0b0a0908; l[2] = 1'b1;
    esel[0] = 0; esel[1] = 2; esel[2] = 4; esel[3] = 0;
    elast[0] = 0; elast[1] = 0; elast[2] = 1; elast[3] = 1;
    wi = 0; c = 0;
    win_ready[1] = 1'b1;
    while (gsel.size() < 4 && c < 80) begin
      in_valid[1] = (wi < 3);
      in_data[1]  = (wi < 3) ? w[wi] : 32'd0;
      in_last[1]  = (wi < 3) ? l[wi] : 1'b0;
      if (win_valid[1]) begin
        gsel.push_back(int'(steer_sel[1]));
        glast.push_back(win_last[1]);
      end
      if (in_valid[1] && in_ready[1]) wi++;
      step();
      c++;
    end
    idle_inputs();
    nvec++;
    if (gsel.size() != 4) begin
      nerr++; $display("FAIL stride2_count windows=%0d required 4", gsel.size());
    end
    for (int k = 0; k < 4 && k < gsel.size(); k++) begin
      nvec++;
      if (gsel[k] != esel[k] || glast[k] !== elast[k]) begin
        nerr++;
        $display("FAIL stride2_window k=%0d sel=%0d last=%b required %0d %b", k, gsel[k], glast[k], esel[k], elast[k]);
      end
    end
    do_reset();
  endtask

  task automatic test_runt();
    in_valid[3] = 1'b1; in_data[3] = 32'hdeadbeef; in_last[3] = 1'b1;
    nvec++;
    if (in_ready[3] !== 1'b1) begin
      nerr++; $display("FAIL runt_ready_before in_ready=%b required 1", in_ready[3]);
    end
    step();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      nvec++;
      if (in_ready[3] !== (c == 2) || win_valid[3] !== 1'b0) begin
        nerr++;
        $display("FAIL runt_cycle c=%0d in_ready=%b win_valid=%b required %b 0", c, in_ready[3], win_valid[3], (c == 2));
      end
      step();
    end
    do_reset();
  endtask

  task automatic test_same_edge();
    in_valid[2] = 1'b1; in_data[2] = 32'h03020100;
    step();
    in_valid[2] = 1'b0;
    step();
    nvec++;
    if (win_valid[2] !== 1'b1 || steer_sel[2] !== 3'd0 || in_ready[2] !== 1'b1) begin
      nerr++;
      $display("FAIL same_edge_present valid=%b sel=%0d in_ready=%b required 1 0 1", win_valid[2], steer_sel[2], in_ready[2]);
    end
    in_valid[2] = 1'b1; in_data[2] = 32'h07060504; win_ready[2] = 1'b1;
    step();
    in_valid[2] = 1'b0; win_ready[2] = 1'b0;
    nvec++;
    if (win_valid[2] !== 1'b0) begin
      nerr++; $display("FAIL same_edge_gap win_valid=%b required 0", win_valid[2]);
    end
    step();
    nvec++;
    if (win_valid[2] !== 1'b1 || steer_sel[2] !== 3'd3 || win_bytes(2) !== 40'h0006050403) begin
      nerr++;
      $display("FAIL same_edge_window valid=%b sel=%0d bytes=%h required 1 3 0006050403", win_valid[2], steer_sel[2], win_bytes(2));
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    int n;
    in_valid[0] = 1'b1; in_data[0] = 32'h33221100;
    step();
    in_valid[0] = 1'b0;
    n = 0;
    while (win_valid[0] !== 1'b1 && n < 10) begin step(); n++; end
    nvec++;
    if (win_valid[0] !== 1'b1 || in_ready[0] !== 1'b1) begin
      nerr++; $display("FAIL reset_mid_setup win_valid=%b in_ready=%b required 1 1", win_valid[0], in_ready[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if (win_valid[0] !== 1'b0 || in_ready[0] !== 1'b0 || steer_en[0] !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid_async win_valid=%b in_ready=%b steer_en=%b required 0 0 0", win_valid[0], in_ready[0], steer_en[0]);
    end
    step();
    rst_n = 1'b1;
    #1;
    nvec++;
    if (in_ready[0] !== 1'b0) begin
      nerr++; $display("FAIL reset_mid_release1 in_ready=%b required 0", in_ready[0]);
    end
    step();
    nvec++;
    if (in_ready[0] !== 1'b1 || steer_sel[0] !== 3'd0) begin
      nerr++; $display("FAIL reset_mid_release2 in_ready=%b sel=%0d required 1 0", in_ready[0], steer_sel[0]);
    end
  endtask

  // Reference: each row is a flat pixel list; windows start at 0, S, 2S... while a
  // full window fits, ring index is pixel position mod 8, the final one is flagged.
  task automatic test_random(input int i, input int nrows);
    logic [31:0] wq [$];
    logic        lq [$];
    logic [7:0]  px [$];
    int          esel [$];
    logic [39:0] edat [$];
    logic        elast [$];
    logic [31:0] word;
    logic [39:0] d, cur;
    logic [2:0]  hsel;
    logic [39:0] hdat;
    int          nw, n, widx, cyc, wv, st, es;
    logic        held, el;
    wv = win_of(i);
    st = str_of(i);
    for (int r = 0; r < nrows; r++) begin
      nw = $urandom_range(1, 4);
      px.delete();
      for (int w = 0; w < nw; w++) begin
        word = $urandom;
        wq.push_back(word);
        lq.push_back(w == nw - 1);
        for (int b = 0; b < 4; b++) px.push_back(word[8*b +: 8]);
      end
      n = nw * 4;
      for (int pos = 0; pos + wv <= n; pos += st) begin
        d = '0;
        for (int k = 0; k < wv; k++) d[8*k +: 8] = px[pos + k];
        esel.push_back(pos % 8);
        edat.push_back(d);
        elast.push_back(pos + st + wv > n);
      end
    end
    widx = 0; cyc = 0; held = 1'b0; hsel = '0; hdat = '0;
    while ((widx < wq.size() || esel.size() > 0) && cyc < 3000) begin
      in_valid[i]  = (widx < wq.size()) && ($urandom_range(0, 3) != 0);
      in_data[i]   = (widx < wq.size()) ? wq[widx] : 32'd0;
      in_last[i]   = (widx < wq.size()) ? lq[widx] : 1'b0;
      win_ready[i] = ($urandom_range(0, 2) != 0);
      cur = win_bytes(i);
      if (held) begin
        nvec++;
        if (win_valid[i] !== 1'b1 || steer_sel[i] !== hsel || cur !== hdat) begin
          nerr++;
          $display("FAIL rand_hold inst=%0d valid=%b sel=%0d bytes=%h required 1 %0d %h", i, win_valid[i], steer_sel[i], cur, hsel, hdat);
        end
      end
      held = 1'b0;
      if (win_valid[i] === 1'b1) begin
        if (win_ready[i]) begin
          nvec++;
          if (esel.size() == 0) begin
            nerr++; $display("FAIL rand_extra_window inst=%0d sel=%0d required none", i, steer_sel[i]);
          end else begin
            es = esel.pop_front();
            d  = edat.pop_front();
            el = elast.pop_front();
            if (int'(steer_sel[i]) != es || cur !== d || win_last[i] !== el) begin
              nerr++;
              $display("FAIL rand_window inst=%0d sel=%0d bytes=%h last=%b required %0d %h %b",
                       i, steer_sel[i], cur, win_last[i], es, d, el);
            end
          end
        end else begin
          held = 1'b1;
          hsel = steer_sel[i];
          hdat = cur;
        end
      end
      if (in_valid[i] && in_ready[i]) widx++;
      step();
      cyc++;
    end
    idle_inputs();
    nvec++;
    if (cyc >= 3000) begin
      nerr++;
      $display("FAIL rand_timeout inst=%0d words_left=%0d windows_left=%0d required 0 0", i, wq.size() - widx, esel.size());
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_backpressure();
    test_stride2();
    test_runt();
    test_same_edge();
    test_reset_mid();
    for (int i = 0; i < NI; i++) begin
      do_reset();
      test_random(i, 8);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
